tpu_host_seq: RTL and testbench

TPU_HOST_SEQ -- requirements
Module: tpu_host_seq

---
 rtl/tpu_host_seq_if.sv | 56 +++++
 rtl/tpu_host_seq.sv | 213 +++++++++++++++++++++
 tb/tb_tpu_host_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_host_seq_if.sv
// Host/array bus bundle for tpu_host_seq.
//
// Groups the three streams the sequencer touches:
//   - host write stream:  in_valid / in_ready / in_data
//   - result stream:      out_valid / out_ready / out_data
//   - array-side port:    tpu_r_w / tpu_addr / tpu_dataIn (sequencer drives),
//                         tpu_dataOut (array drives, combinational from tpu_addr)
//
// Modports:
//   master - the sequencer view (drives in_ready, the result stream and the array port)
//   slave  - the environment view (host producer, result consumer and the array)
interface tpu_host_seq_if #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned DATAW = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;

  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;

  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_dataIn;
  logic [DATAW-1:0] tpu_dataOut;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    output tpu_r_w,
    output tpu_addr,
    output tpu_dataIn,
    input  tpu_dataOut
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    input  tpu_r_w,
    input  tpu_addr,
    input  tpu_dataIn,
    output tpu_dataOut
  );

endinterface

// File: rtl/tpu_host_seq.sv
// Host-side job sequencer for a DIM x DIM systolic array.
//
// A job streams A (DIM row words), B (DIM row words) and optionally C (2*DIM half-row
// words) from the host into the array, issues the start write, waits a fixed number of
// cycles for the array to compute, then reads the 2*DIM result words back out to the
// host one at a time.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   go, cfg_load_c   one-cycle job request (IDLE only) and C-preload option
//   busy, done       high outside IDLE; one-cycle pulse after the last result word
//   bus (master)     host write stream, result stream and array port
//
// Every array-side output is a flop: an accepted host word appears on the array port
// one cycle later for exactly one cycle. in_ready is withheld while that write is on
// the bus, so the array never sees back-to-back writes during a load phase.
module tpu_host_seq #(
  parameter int unsigned DIM      = 8,
  parameter int unsigned ADDRW    = 16,
  parameter int unsigned DATAW    = 64,
  parameter int unsigned WAIT_CYC = 3 * DIM + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic           cfg_load_c,
  output logic           busy,
  output logic           done,
  tpu_host_seq_if.master bus
);

  // Word counter must reach 2*DIM (C phase length).
  localparam int unsigned CntW  = $clog2(2 * DIM) + 1;
  // Wait counter runs 0 .. WAIT_CYC-1.
  localparam int unsigned WaitW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoadA = 3'd1;
  localparam logic [2:0] StLoadB = 3'd2;
  localparam logic [2:0] StLoadC = 3'd3;
  localparam logic [2:0] StStart = 3'd4;
  localparam logic [2:0] StWait  = 3'd5;
  localparam logic [2:0] StRead  = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  localparam logic [ADDRW-1:0] BAddr     = ADDRW'(32'h0200);
  localparam logic [ADDRW-1:0] StartAddr = ADDRW'(32'h0400);

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic             load_c_q, load_c_d;
  logic             wr_q, wr_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] wdata_q, wdata_d;
  logic             rd_pend_q, rd_pend_d;
  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_data_q, out_data_d;

  logic             in_load;
  logic [CntW-1:0]  load_len;
  logic             in_ready;
  logic             accept;

  // A-row address: 0x0100 + r*DIM.
  function automatic logic [ADDRW-1:0] a_addr(input logic [CntW-1:0] r);
    return ADDRW'(32'h0100 + 32'(r) * DIM);
  endfunction

  // C / result half-row address: 0x0300 + (k>>1)*2*DIM + (k&1)*DIM.
  function automatic logic [ADDRW-1:0] c_addr(input logic [CntW-1:0] k);
    return ADDRW'(32'h0300 + 32'(k >> 1) * 2 * DIM + 32'(k[0]) * DIM);
  endfunction

  always_comb begin
    in_load  = (state_q == StLoadA) || (state_q == StLoadB) || (state_q == StLoadC);
    load_len = (state_q == StLoadC) ? CntW'(2 * DIM) : CntW'(DIM);
    // Hold off while the previous word is being written, and once the phase is full.
    in_ready = in_load && !wr_q && (cnt_q != load_len);
    accept   = in_ready && bus.in_valid;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    load_c_d    = load_c_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = '0;
    rd_pend_d   = rd_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      StIdle: begin
        if (go) begin
          state_d  = StLoadA;
          load_c_d = cfg_load_c;
          cnt_d    = '0;
        end
      end

      StLoadA, StLoadB, StLoadC: begin
        if (accept) begin
          wr_d    = 1'b1;
          wdata_d = bus.in_data;
          cnt_d   = cnt_q + 1'b1;
          if (state_q == StLoadA) begin
            addr_d = a_addr(cnt_q);
          end else if (state_q == StLoadB) begin
            addr_d = BAddr;
          end else begin
            addr_d = c_addr(cnt_q);
          end
        end else if (cnt_q == load_len) begin
          // Phase full: this is the cycle the last word is on the array port.
          cnt_d = '0;
          if (state_q == StLoadA) begin
            state_d = StLoadB;
          end else if ((state_q == StLoadB) && load_c_q) begin
            state_d = StLoadC;
          end else begin
            // Register the start write so it coincides with the START state.
            state_d = StStart;
            wr_d    = 1'b1;
            addr_d  = StartAddr;
          end
        end
      end

      StStart: begin
        state_d = StWait;
        wcnt_d  = '0;
        cnt_d   = '0;
      end

      StWait: begin
        if (wcnt_q == WaitW'(WAIT_CYC - 1)) begin
          // Launch the first read address so it is on the bus in the first READ cycle.
          state_d   = StRead;
          addr_d    = c_addr('0);
          rd_pend_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      StRead: begin
        if (rd_pend_q) begin
          out_data_d  = bus.tpu_dataOut;
          out_valid_d = 1'b1;
          rd_pend_d   = 1'b0;
        end
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_q == CntW'(2 * DIM - 1)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            addr_d    = c_addr(cnt_q + 1'b1);
            rd_pend_d = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      load_c_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      load_c_q    <= load_c_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.tpu_r_w    = wr_q;
  assign bus.tpu_addr   = addr_q;
  assign bus.tpu_dataIn = wdata_q;

endmodule

// File: tb/tb_tpu_host_seq.sv
// Bench for tpu_host_seq: a behavioural array model answers reads, a table of jobs is
// applied in a loop, and expected array writes / result words are queued up front and
// popped as the DUT produces them. Hand-written sequences cover reset and IDLE input.
module tb_tpu_host_seq;

  localparam int DIM = 8;

  typedef struct {
    bit          cfg;
    int          a_kind;      // 0 identity, 1 random 0..7
    int          b_kind;      // 0 row k = k+1, 1 random 0..7
    logic [63:0] c_word;
    int          stall;       // out_ready low cycles per word
    bit          rand_valid;
    bit          sgo;         // spurious go during LOAD_B and WAIT
    int          exp_lat;
    int          exp_done;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0;
  logic cfg_load_c = 1'b0;
  logic busy;
  logic done;

  tpu_host_seq_if #(.ADDRW(16), .DATAW(64)) bus ();

  tpu_host_seq #(.DIM(DIM), .ADDRW(16), .DATAW(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .cfg_load_c(cfg_load_c),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Array model: memory, B row capture in arrival order, product on the start write.
  logic [63:0] mem [0:4095];
  logic [63:0] b_rows [0:7];
  logic [2:0]  b_idx;
  logic        c_wr;

  assign bus.tpu_dataOut = mem[bus.tpu_addr[11:0]];

  function automatic logic [63:0] stub_word(input int r, input int h);
    logic [63:0] aw, cw, bw, res;
    int s;
    aw  = mem[12'(32'h100 + r * 8)];
    cw  = c_wr ? mem[12'(32'h300 + r * 16 + h * 8)] : 64'h0;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      s = int'(cw[16*l +: 16]);
      for (int k = 0; k < 8; k++) begin
        bw = b_rows[k];
        s += int'(aw[8*k +: 8]) * int'(bw[8*(4*h+l) +: 8]);
      end
      res[16*l +: 16] = 16'(s);
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      b_idx <= '0;
      c_wr  <= 1'b0;
    end else if (bus.tpu_r_w) begin
      if (bus.tpu_addr == 16'h0400) begin
        for (int r = 0; r < 8; r++)
          for (int h = 0; h < 2; h++)
            mem[12'(32'h300 + r * 16 + h * 8)] <= stub_word(r, h);
        b_idx <= '0;
        c_wr  <= 1'b0;
      end else begin
        mem[bus.tpu_addr[11:0]] <= bus.tpu_dataIn;
        if (bus.tpu_addr == 16'h0200) begin
          b_rows[b_idx] <= bus.tpu_dataIn;
          b_idx         <= b_idx + 3'd1;
        end
        if (bus.tpu_addr[11:8] == 4'h3) c_wr <= 1'b1;
      end
    end
  end

  // Job matrices and scoreboard queues.
  int          ja [8][8];
  int          jb [8][8];
  logic [63:0] jc;
  logic [63:0] words [$];
  wr_t         wq [$];
  logic [63:0] oq [$];
  vec_t        tbl [4];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int lat = -1;
  int cyc = 0;
  int start_cyc = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int r, input int h);
    logic [63:0] res;
    int s;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      s = int'(jc[16*l +: 16]);
      for (int k = 0; k < 8; k++) s += ja[r][k] * jb[k][4*h+l];
      res[16*l +: 16] = 16'(s);
    end
    return res;
  endfunction

  task automatic prep_job(input vec_t v);
    logic [63:0] w;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (v.a_kind == 0) ja[r][c] = (r == c) ? 1 : 0;
        else ja[r][c] = int'($urandom_range(0, 7));
        if (v.b_kind == 0) jb[r][c] = r + 1;
        else jb[r][c] = int'($urandom_range(0, 7));
      end
    jc = v.cfg ? v.c_word : 64'h0;
    words.delete();
    wq.delete();
    oq.delete();
    for (int r = 0; r < 8; r++) begin
      w = '0;
      for (int c = 0; c < 8; c++) w[8*c +: 8] = 8'(ja[r][c]);
      words.push_back(w);
      wq.push_back('{a: 16'(32'h100 + r * 8), d: w});
    end
    for (int k = 0; k < 8; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(jb[k][j]);
      words.push_back(w);
      wq.push_back('{a: 16'h0200, d: w});
    end
    if (v.cfg) begin
      for (int k = 0; k < 16; k++) begin
        words.push_back(v.c_word);
        wq.push_back('{a: 16'(32'h300 + (k >> 1) * 16 + (k & 1) * 8), d: v.c_word});
      end
    end
    wq.push_back('{a: 16'h0400, d: 64'h0});
    for (int k = 0; k < 16; k++) oq.push_back(exp_word(k >> 1, k & 1));
  endtask

  task automatic pulse_go(input bit cfg);
    @(negedge clk);
    go = 1'b1;
    cfg_load_c = cfg;
    @(negedge clk);
    go = 1'b0;
    cfg_load_c = 1'b0;
  endtask

  task automatic stream(input bit rv, input bit sgo);
    int i;
    int t;
    bit acc;
    i = 0;
    t = 0;
    while (i < words.size() && t < 1000) begin
      @(negedge clk);
      go = (sgo && i == DIM + 2);
      bus.in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = words[i];
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) i++;
      t++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    go = 1'b0;
    chk("stream_words", 64'(i), 64'(words.size()));
  endtask

  task automatic drain_out(input int stall, input bit sgo);
    int hold;
    int t;
    bit cons;
    hold = 0;
    t = 0;
    while (t < 2000) begin
      @(negedge clk);
      if (done) break;
      go = (sgo && t == 5);
      if (bus.out_valid) begin
        if (hold < stall) begin
          bus.out_ready = 1'b0;
          hold++;
        end else begin
          bus.out_ready = 1'b1;
        end
      end else begin
        bus.out_ready = (stall == 0);
      end
      cons = bus.out_valid && bus.out_ready;
      @(posedge clk);
      if (cons) hold = 0;
      t++;
    end
    go = 1'b0;
    bus.out_ready = 1'b0;
    chk("done_in_time", 64'(t < 2000), 64'd1);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int d0;
    prep_job(v);
    lat = -1;
    d0 = done_cnt;
    pulse_go(v.cfg);
    stream(v.rand_valid, v.sgo);
    drain_out(v.stall, v.sgo);
    repeat (3) @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(v.exp_done));
    chk({tag, "_read_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, "_writes_left"}, 64'(wq.size()), 64'd0);
    chk({tag, "_words_left"}, 64'(oq.size()), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_tpu_r_w"}, 64'(bus.tpu_r_w), 64'd0);
    chk({tag, "_tpu_addr"}, 64'(bus.tpu_addr), 64'd0);
    chk({tag, "_tpu_dataIn"}, bus.tpu_dataIn, 64'd0);
  endtask

  task automatic monitor();
    bit pw, pov, por;
    logic [63:0] pod;
    wr_t e;
    pw = 0;
    pov = 0;
    por = 0;
    pod = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        armed = 1'b0;
        pw = 0;
        pov = 0;
        por = 0;
      end else begin
        if (bus.tpu_r_w) begin
          if (pw) chk("no_back_to_back_write", 64'(bus.tpu_addr), 64'h0400);
          if (wq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_unexpected: got addr %h data %h, expected no write",
                     bus.tpu_addr, bus.tpu_dataIn);
          end else begin
            e = wq.pop_front();
            chk("wr_addr", 64'(bus.tpu_addr), 64'(e.a));
            chk("wr_data", bus.tpu_dataIn, e.d);
          end
          if (bus.tpu_addr == 16'h0400) begin
            armed = 1'b1;
            start_cyc = cyc;
          end
        end else begin
          chk("idle_dataIn", bus.tpu_dataIn, 64'h0);
          if (armed && bus.tpu_addr == 16'h0300) begin
            lat = cyc - start_cyc;
            armed = 1'b0;
          end
        end
        if (pov && !por) begin
          chk("stall_valid", 64'(bus.out_valid), 64'd1);
          chk("stall_data", bus.out_data, pod);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (oq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: got %h, expected no result word", bus.out_data);
          end else begin
            chk("out_data", bus.out_data, oq.pop_front());
          end
        end
        if (done) done_cnt++;
        pw  = bus.tpu_r_w;
        pov = bus.out_valid;
        por = bus.out_ready;
        pod = bus.out_data;
      end
    end
  endtask

  initial begin
    int d0;
    tbl[0] = '{cfg: 1'b0, a_kind: 0, b_kind: 0, c_word: 64'h0, stall: 0, rand_valid: 1'b0,
               sgo: 1'b0, exp_lat: 26, exp_done: 1};
    tbl[1] = '{cfg: 1'b1, a_kind: 0, b_kind: 0, c_word: 64'h0001_0001_0001_0001, stall: 0,
               rand_valid: 1'b0, sgo: 1'b0, exp_lat: 26, exp_done: 1};
    tbl[2] = '{cfg: 1'b1, a_kind: 1, b_kind: 1, c_word: 64'h0005_0003_0007_0002, stall: 10,
               rand_valid: 1'b1, sgo: 1'b0, exp_lat: 26, exp_done: 1};
    tbl[3] = '{cfg: 1'b0, a_kind: 1, b_kind: 1, c_word: 64'h0, stall: 2, rand_valid: 1'b1,
               sgo: 1'b1, exp_lat: 26, exp_done: 1};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Host data in IDLE must not be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      #1;
      chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 4; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    // Reset during WAIT discards the job; the next job starts clean.
    prep_job(tbl[0]);
    d0 = done_cnt;
    pulse_go(1'b0);
    stream(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_reset("mid_reset");
    chk("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);
    wq.delete();
    oq.delete();
    rst_n = 1'b1;
    run_job(tbl[1], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
